fetch_unit_hs: RTL and testbench
================================

# fetch_unit_hs

Parametrised fetch stage for the RockWave core that replaces the fixed one-cycle instruction-memory assumption with a req/ack handshake, so multi-cycle memories are supported. It holds the program counter, fetches one instruction per fetch phase, drives `stall_fetch` to the state machine while memory is busy, and registers PC, next-PC and instruction for Decode. An optional watchdog converts a hung fetch into a NOP with a fault flag.

## Interface
Parameters:
- `XLEN`, 32: data and PC width.
- `AWIDTH`, 14: instruction-memory word-address width. Must satisfy `AWIDTH <= XLEN-2`.
- `RESET_VECTOR`, 32'h0000_0000: PC value after reset.
- `TIMEOUT`, 16: maximum WAIT cycles before fault. Range 1..255.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: global clock.
- `rst` in 1: synchronous active-high reset.
- `phase_fetch` in 1: fetch phase from StateMachine.
- `phase_writeback` in 1: writeback phase from StateMachine.
- `jump_state_wf` in 1: next PC is the jump target.
- `regdata_for_pc` in XLEN: jump target.
- `imem_req` out 1: request to instruction memory.
- `imem_addr` out AWIDTH: word address, equal to `pc[AWIDTH+1:2]` captured at issue.
- `imem_ack` in 1: data valid on `imem_rdata`.
- `imem_rdata` in XLEN: instruction word.
- `curr_pc_fd` out XLEN: PC of the fetched instruction.
- `next_pc_fd` out XLEN: that PC + 4.
- `inst` out XLEN: registered instruction.
- `inst_valid` out 1: `inst`, `curr_pc_fd` and `next_pc_fd` hold a completed fetch.
- `stall_fetch` out 1: fetch phase must be held.
- `fetch_fault` out 1: sticky timeout flag. Tied to 0 when `FETCH_TIMEOUT_EN` is undefined.

## Operation
- PC register:
  - Reset value is `RESET_VECTOR`.
  - On `phase_writeback`, PC loads `{regdata_for_pc[XLEN-1:2],2'b00}` if `jump_state_wf`, else `pc+4`.
  - Addition wraps modulo 2^XLEN.
  - Otherwise PC holds.
- FSM states: IDLE, WAIT.
  - **IDLE:**
    - On `phase_fetch`, register `imem_addr`, set `imem_req=1`, clear the timer, go to WAIT.
    - `imem_ack` seen in IDLE is ignored.
  - **WAIT:**
    - `imem_req` stays 1 and `imem_addr` stays stable.
    - On `imem_ack`, capture `imem_rdata` into `inst`, capture `curr_pc_fd=pc` and `next_pc_fd=pc+4`, set `inst_valid=1`, drop `imem_req`, and go to IDLE.
- `stall_fetch`, combinational: `(IDLE & phase_fetch) | (WAIT & ~imem_ack)`.
- `inst_valid`:
  - Clears when a new fetch is issued.
  - Set in the cycle after ack.
  - Otherwise holds.
- `phase_writeback` asserted during WAIT updates PC. The in-flight fetch still completes with its registered address, and `curr_pc_fd` takes the PC value captured at issue.
- Reset in any state forces IDLE. A late ack after reset is ignored.
- Reset values of outputs:
  - `imem_req=0`, `imem_addr=0`.
  - `curr_pc_fd=0`, `next_pc_fd=0`, `inst=0`.
  - `inst_valid=0`, `fetch_fault=0`.
  - `stall_fetch` follows its combinational equation with state IDLE.

## Timing
- Issue cycle T: `phase_fetch` is high and `stall_fetch` is high. `imem_req` and `imem_addr` are registered and visible at T+1.
- The earliest legal ack is T+1. `inst_valid` is visible at T+2.
- With an ack in cycle T+k, `stall_fetch` is low in T+k. The best-case fetch latency is 2 cycles.
- The timer counts WAIT cycles without ack. Ack and timer expiry in the same cycle: ack wins and no fault is raised.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - After `TIMEOUT` consecutive WAIT cycles without ack, load `inst=32'h0000_0013` (NOP) with PCs captured as for a normal fetch.
  - Set `inst_valid=1` and `fetch_fault=1`, drop `imem_req`, and return to IDLE.
  - `fetch_fault` clears only on `rst`.
- `FETCH_TIMEOUT_EN` undefined: no timer is built, WAIT lasts until ack, and `fetch_fault` is constant 0.

## Test plan
- **Reset:** `rst` high for 2 cycles with `RESET_VECTOR=32'h100` -> all outputs at reset values. The first fetch drives `imem_addr=0x40`.
- **Zero-wait fetch:** ack at T+1 with rdata 0x00500093 -> `inst=0x00500093`, `curr_pc_fd=0x100`, `next_pc_fd=0x104`, `inst_valid` at T+2. `stall_fetch` high only in T.
- **3-cycle memory:** ack at T+3 -> `stall_fetch` high T..T+2 and low at T+3. `imem_addr` is constant T+1..T+3.
- **Jump:** `phase_writeback` with `jump_state_wf=1` and target 0x203 -> PC=0x200. The next fetch drives `imem_addr=0x80`. A non-jump writeback at PC=0xFFFF_FFFC wraps PC to 0.
- **Reset mid-WAIT:** `rst` asserted at T+2, then ack at T+3 -> `imem_req=0`, `inst_valid=0`, `inst` unchanged at 0.
- **Timeout (`FETCH_TIMEOUT_EN`, `TIMEOUT=4`):** no ack -> NOP captured after 4 WAIT cycles, `fetch_fault=1`. Also check ack arriving on cycle 4 gives normal data with no fault.

Source files
------------

// File: rtl/fetch_unit_hs.sv
// fetch_unit_hs -- RockWave fetch stage with a req/ack instruction-memory
// handshake, so memories of any latency can sit behind it.
//
// Build option: define FETCH_TIMEOUT_EN to build the fetch watchdog. With it,
// a fetch left unanswered for TIMEOUT WAIT cycles completes as a NOP and
// raises the sticky fetch_fault flag. Without it, WAIT lasts until ack and
// fetch_fault is constant 0.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   phase_fetch         fetch phase from the state machine
//   phase_writeback     writeback phase; advances the PC
//   jump_state_wf       PC takes regdata_for_pc (word aligned) at writeback
//   regdata_for_pc      jump target
//   imem_req/imem_addr  registered request and word address to memory
//   imem_ack/imem_rdata memory response
//   curr_pc_fd          PC of the fetched instruction
//   next_pc_fd          curr_pc_fd + 4
//   inst, inst_valid    registered instruction and its valid flag
//   stall_fetch         hold the fetch phase (combinational)
//   fetch_fault         sticky watchdog flag
//
// Handshake: imem_req rises the cycle after a fetch is issued and stays high,
// with imem_addr stable, until the cycle after imem_ack (or watchdog expiry).
// imem_ack is only meaningful while the FSM is in WAIT; in IDLE it is ignored,
// which also drops a late ack belonging to a fetch cancelled by reset.

module fetch_unit_hs #(
  parameter int               XLEN         = 32,
  parameter int               AWIDTH       = 14,
  parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0000_0000,
  parameter int               TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              phase_fetch,
  input  logic              phase_writeback,
  input  logic              jump_state_wf,
  input  logic [XLEN-1:0]   regdata_for_pc,
  output logic              imem_req,
  output logic [AWIDTH-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [XLEN-1:0]   imem_rdata,
  output logic [XLEN-1:0]   curr_pc_fd,
  output logic [XLEN-1:0]   next_pc_fd,
  output logic [XLEN-1:0]   inst,
  output logic              inst_valid,
  output logic              stall_fetch,
  output logic              fetch_fault
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
  localparam logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   issue_pc_q, issue_pc_d;  // PC at issue; writeback may move pc_q mid-fetch
  logic              req_q, req_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   curr_q, curr_d;
  logic [XLEN-1:0]   next_q, next_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic              valid_q, valid_d;
  logic              done;

  // Jump targets are forced word aligned, so the low two bits are dropped.
  logic unused_bits;
  assign unused_bits = ^regdata_for_pc[1:0];

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] timer_q, timer_d;
  logic       fault_q, fault_d;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    issue_pc_d = issue_pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    curr_d     = curr_q;
    next_d     = next_q;
    inst_d     = inst_q;
    valid_d    = valid_q;
    done       = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    timer_d    = timer_q;
    fault_d    = fault_q;
`endif

    if (phase_writeback) begin
      pc_d = jump_state_wf ? {regdata_for_pc[XLEN-1:2], 2'b00} : pc_q + PC_STEP;
    end

    case (state_q)
      IDLE: begin
        if (phase_fetch) begin
          state_d    = WAIT;
          req_d      = 1'b1;
          addr_d     = pc_q[AWIDTH+1:2];
          issue_pc_d = pc_q;
          valid_d    = 1'b0;
`ifdef FETCH_TIMEOUT_EN
          timer_d    = 8'd0;
`endif
        end
      end
      WAIT: begin
        // Ack beats a watchdog expiry landing in the same cycle.
        if (imem_ack) begin
          done   = 1'b1;
          inst_d = imem_rdata;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (timer_q == 8'(TIMEOUT - 1)) begin
          done    = 1'b1;
          inst_d  = NOP_INST;
          fault_d = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      state_d = IDLE;
      req_d   = 1'b0;
      valid_d = 1'b1;
      curr_d  = issue_pc_q;
      next_d  = issue_pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_VECTOR;
      issue_pc_q <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      curr_q     <= '0;
      next_q     <= '0;
      inst_q     <= '0;
      valid_q    <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      timer_q    <= 8'd0;
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      issue_pc_q <= issue_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      curr_q     <= curr_d;
      next_q     <= next_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
`ifdef FETCH_TIMEOUT_EN
      timer_q    <= timer_d;
      fault_q    <= fault_d;
`endif
    end
  end

  assign stall_fetch = ((state_q == IDLE) & phase_fetch) |
                       ((state_q == WAIT) & ~imem_ack);
  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign curr_pc_fd  = curr_q;
  assign next_pc_fd  = next_q;
  assign inst        = inst_q;
  assign inst_valid  = valid_q;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit_hs.sv
module tb_fetch_unit_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        phase_fetch, phase_writeback, jump_state_wf;
  logic [31:0] regdata_for_pc;
  logic        imem_req;
  logic [13:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] curr_pc_fd, next_pc_fd, inst;
  logic        inst_valid, stall_fetch, fetch_fault;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] pc_model;
  logic        exp_fault;
  logic [95:0] exp_q[$];  // {inst, curr_pc, next_pc}

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fetch_unit_hs #(
    .XLEN(32), .AWIDTH(14), .RESET_VECTOR(32'h100), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .phase_fetch(phase_fetch), .phase_writeback(phase_writeback),
    .jump_state_wf(jump_state_wf), .regdata_for_pc(regdata_for_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .curr_pc_fd(curr_pc_fd), .next_pc_fd(next_pc_fd), .inst(inst),
    .inst_valid(inst_valid), .stall_fetch(stall_fetch), .fetch_fault(fetch_fault)
  );

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " imem_req"},    32'(imem_req), 32'd0);
    chk({tag, " imem_addr"},   32'(imem_addr), 32'd0);
    chk({tag, " curr_pc_fd"},  curr_pc_fd, 32'd0);
    chk({tag, " next_pc_fd"},  next_pc_fd, 32'd0);
    chk({tag, " inst"},        inst, 32'd0);
    chk({tag, " inst_valid"},  32'(inst_valid), 32'd0);
    chk({tag, " fetch_fault"}, 32'(fetch_fault), 32'd0);
    chk({tag, " stall_fetch"}, 32'(stall_fetch), 32'(phase_fetch));
  endtask

  // Compare the completed fetch against the oldest expected record.
  task automatic score(input string name);
    logic [95:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty, got inst %h", name, inst);
    end else begin
      e = exp_q.pop_front();
      chk({name, " inst"},       inst,       e[95:64]);
      chk({name, " curr_pc_fd"}, curr_pc_fd, e[63:32]);
      chk({name, " next_pc_fd"}, next_pc_fd, e[31:0]);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Issue at T, ack at T+k, result visible at T+k+1. Starts and ends at posedge+1.
  task automatic do_fetch(input int k, input logic [31:0] rdata,
                          input logic [31:0] exp_pc, input string name);
    logic [31:0] a;
    a = {18'd0, exp_pc[15:2]};
    phase_fetch = 1'b1;
    @(negedge clk);
    chk({name, " stall@issue"}, 32'(stall_fetch), 32'd1);
    step();
    for (int j = 1; j <= k; j++) begin
      if (j == k) begin
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        exp_q.push_back({rdata, exp_pc, exp_pc + 32'd4});
      end
      @(negedge clk);
      chk($sformatf("%s req@T+%0d", name, j),   32'(imem_req),   32'd1);
      chk($sformatf("%s addr@T+%0d", name, j),  32'(imem_addr),  a);
      chk($sformatf("%s stall@T+%0d", name, j), 32'(stall_fetch), (j == k) ? 32'd0 : 32'd1);
      chk($sformatf("%s valid@T+%0d", name, j), 32'(inst_valid), 32'd0);
      step();
    end
    imem_ack    = 1'b0;
    phase_fetch = 1'b0;
    @(negedge clk);
    chk({name, " valid"}, 32'(inst_valid),  32'd1);
    chk({name, " req"},   32'(imem_req),    32'd0);
    chk({name, " stall"}, 32'(stall_fetch), 32'd0);
    chk({name, " fault"}, 32'(fetch_fault), 32'(exp_fault));
    score(name);
    step();
  endtask

  task automatic do_wb(input logic jump, input logic [31:0] target);
    phase_writeback = 1'b1;
    jump_state_wf   = jump;
    regdata_for_pc  = target;
    step();
    phase_writeback = 1'b0;
    jump_state_wf   = 1'b0;
    pc_model = jump ? {target[31:2], 2'b00} : pc_model + 32'd4;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          k;
    logic [31:0] rdata;
    logic [31:0] exp_pc;
    logic        wb_jump;
    logic [31:0] wb_target;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1, 32'h0050_0093, 32'h0000_0100, 1'b0, 32'h0};
    vecs[1] = '{3, 32'h1234_5678, 32'h0000_0104, 1'b1, 32'h0000_0203};
    vecs[2] = '{1, 32'hdead_beef, 32'h0000_0200, 1'b0, 32'h0};
    vecs[3] = '{2, 32'h0000_0013, 32'h0000_0204, 1'b1, 32'hffff_fffe};
    vecs[4] = '{1, 32'hcafe_f00d, 32'hffff_fffc, 1'b0, 32'h0};
    vecs[5] = '{4, 32'h0bad_f00d, 32'h0000_0000, 1'b0, 32'h0};

    rst = 1'b1;
    phase_fetch = 1'b0; phase_writeback = 1'b0; jump_state_wf = 1'b0;
    regdata_for_pc = '0; imem_ack = 1'b0; imem_rdata = '0;
    exp_fault = 1'b0;
    pc_model = 32'h100;

    // Reset held for two cycles.
    step();
    step();
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();
    @(negedge clk);
    chk_reset_outputs("post_reset");
    step();

    // Table: fetch with a given memory latency, then a writeback.
    for (int i = 0; i < 6; i++) begin
      do_fetch(vecs[i].k, vecs[i].rdata, vecs[i].exp_pc, $sformatf("vec%0d", i));
      do_wb(vecs[i].wb_jump, vecs[i].wb_target);
    end

    // Ack while IDLE must not disturb the held result.
    imem_ack   = 1'b1;
    imem_rdata = 32'h5555_aaaa;
    @(negedge clk);
    chk("idle_ack stall", 32'(stall_fetch), 32'd0);
    chk("idle_ack req",   32'(imem_req),    32'd0);
    step();
    imem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack inst",  inst,             32'h0bad_f00d);
    chk("idle_ack valid", 32'(inst_valid),  32'd1);
    step();

    // Writeback during WAIT: fetch keeps its issue address and PC.
    begin
      logic [31:0] p;
      p = pc_model;
      phase_fetch = 1'b1;
      step();
      phase_writeback = 1'b1;
      @(negedge clk);
      chk("wbwait addr1", 32'(imem_addr), {18'd0, p[15:2]});
      step();
      phase_writeback = 1'b0;
      pc_model = p + 32'd4;
      imem_ack   = 1'b1;
      imem_rdata = 32'h0000_600d;
      exp_q.push_back({32'h0000_600d, p, p + 32'd4});
      @(negedge clk);
      chk("wbwait addr2", 32'(imem_addr),   {18'd0, p[15:2]});
      chk("wbwait stall", 32'(stall_fetch), 32'd0);
      step();
      imem_ack = 1'b0;
      phase_fetch = 1'b0;
      @(negedge clk);
      chk("wbwait valid", 32'(inst_valid), 32'd1);
      score("wbwait");
      step();
      do_fetch(1, 32'h0000_1111, pc_model, "after_wbwait");
    end

    // Random latencies and payloads against the PC model.
    for (int i = 0; i < 6; i++) begin
      do_fetch($urandom_range(1, 4), $urandom, pc_model, $sformatf("rnd%0d", i));
      do_wb(1'($urandom_range(0, 1)), $urandom);
    end

`ifdef FETCH_TIMEOUT_EN
    // No ack: NOP after TIMEOUT WAIT cycles, fault set and sticky.
    begin
      logic [31:0] p;
      p = pc_model;
      phase_fetch = 1'b1;
      step();
      for (int j = 1; j <= 4; j++) begin
        @(negedge clk);
        chk($sformatf("tmo req@T+%0d", j),   32'(imem_req),    32'd1);
        chk($sformatf("tmo fault@T+%0d", j), 32'(fetch_fault), 32'd0);
        step();
      end
      phase_fetch = 1'b0;
      exp_fault = 1'b1;
      exp_q.push_back({32'h0000_0013, p, p + 32'd4});
      @(negedge clk);
      chk("tmo valid", 32'(inst_valid),  32'd1);
      chk("tmo fault", 32'(fetch_fault), 32'd1);
      chk("tmo req",   32'(imem_req),    32'd0);
      score("tmo");
      step();
      do_fetch(2, 32'h7777_0000, pc_model, "after_tmo");
    end
`endif

    // Reset while WAIT, then a late ack that must be ignored.
    phase_fetch = 1'b1;
    step();                       // T+1
    phase_fetch = 1'b0;
    step();                       // T+2
    rst = 1'b1;
    step();                       // T+3
    rst = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hffff_0000;
    exp_fault  = 1'b0;
    pc_model   = 32'h100;
    @(negedge clk);
    chk("rst_wait req",   32'(imem_req),    32'd0);
    chk("rst_wait valid", 32'(inst_valid),  32'd0);
    chk("rst_wait inst",  inst,             32'd0);
    chk("rst_wait stall", 32'(stall_fetch), 32'd0);
    step();
    imem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack valid", 32'(inst_valid),  32'd0);
    chk("late_ack inst",  inst,             32'd0);
    chk("late_ack fault", 32'(fetch_fault), 32'd0);
    step();
    do_fetch(1, 32'h0000_00ef, 32'h100, "after_rst");

    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
